// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Serial receive front end. Recovers DATA_BITS-wide frames (LSB first, one
// start bit, one stop bit) from the asynchronous line `rx` using an
// OVERSAMPLE x baud tick. Adds input synchronisation, start-bit validation,
// 3-sample majority voting at mid-bit and framing-error detection.
//
// Ports:
//   clk       system clock, rising edge
//   res       asynchronous active-high reset
//   rx_tick   one-clk enable at OVERSAMPLE x baud
//   rx        asynchronous serial line, idle high
//   rx_data   last received byte, held until the next frame completes
//   rx_valid  one-clk pulse: rx_data updated with a good frame
//   frame_err one-clk pulse: stop bit sampled low (rx_data still updated)
//   rx_busy   high from validated start bit until return to idle
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0;
  logic                 s1;
  logic                 maj;
  logic                 at_dec;
  logic                 at_wrap;

  assign rxs = sync[1];

  // Third vote is the live sample on the decision tick itself.
  assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign at_dec  = (tcnt == T_DEC);
  assign at_wrap = (tcnt == T_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync <= '1;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      // Pulses clear every clk so they last exactly one cycle whatever
      // the tick spacing.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_tick) begin
        if (tcnt == T_S0) s0 <= rxs;
        if (tcnt == T_S1) s1 <= rxs;
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              tcnt  <= '0;
            end
          end
          START: begin
            tcnt <= at_wrap ? '0 : tcnt + 1'b1;
            if (at_dec && maj) begin
              state <= IDLE;
              tcnt  <= '0;
            end else begin
              if (at_dec) rx_busy <= 1'b1;
              if (at_wrap) begin
                state <= DATA;
                bcnt  <= '0;
              end
            end
          end
          DATA: begin
            tcnt <= at_wrap ? '0 : tcnt + 1'b1;
            if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (at_wrap) begin
              if (bcnt == B_LAST) state <= STOP;
              else                bcnt  <= bcnt + 1'b1;
            end
          end
          STOP: begin
            tcnt <= tcnt + 1'b1;
            // Leave at mid stop bit to allow slack for a back-to-back start.
            if (at_dec) begin
              rx_data <= shreg;
              tcnt    <= '0;
              if (maj) begin
                rx_valid <= 1'b1;
                rx_busy  <= 1'b0;
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (rxs) begin
              rx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       res;
  logic       rx_tick = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int tick_div = 4;

  // Observed-event bookkeeping (sampled on the falling edge).
  int   valid_cnt = 0;
  int   ferr_cnt  = 0;
  int   busy_rise = 0;
  int   bad_len   = 0;
  int   both_hi   = 0;
  int   bad_drop  = 0;
  logic valid_q   = 1'b0;
  logic ferr_q    = 1'b0;
  logic busy_q    = 1'b0;
  logic [7:0] got[$];

  uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk      (clk),
    .res      (res),
    .rx_tick  (rx_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide pulse every tick_div clocks, changed on negedge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      if (ph >= tick_div) ph = 0;
      rx_tick = (ph == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      got.push_back(rx_data);
      if (valid_q) bad_len = bad_len + 1;
      if (rx_busy || !busy_q) bad_drop = bad_drop + 1;
    end
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      if (ferr_q) bad_len = bad_len + 1;
    end
    if (rx_valid && frame_err) both_hi = both_hi + 1;
    if (rx_busy && !busy_q) busy_rise = busy_rise + 1;
    valid_q = rx_valid;
    ferr_q  = frame_err;
    busy_q  = rx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (rx_tick !== 1'b1);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) wait_tick();
  endtask

  // noise_bit >= 0: invert the line for one tick interval in the middle of that data bit.
  task automatic send(input logic [7:0] b, input logic stop_v, input int noise_bit);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == noise_bit) begin
        hold(b[i], 8);
        hold(~b[i], 1);
        hold(b[i], 7);
      end else begin
        hold(b[i], 16);
      end
    end
    hold(stop_v, 16);
  endtask

  function automatic logic [31:0] got_at(input int k);
    if (k < got.size()) return {24'h0, got[k]};
    return 32'hdead;
  endfunction

  initial begin
    int br0;
    logic [7:0] pb;
    res = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_data",  {24'h0, rx_data}, 0);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_ferr",  32'(frame_err), 0);
    check("reset_busy",  32'(rx_busy), 0);
    res = 1'b0;
    hold(1'b1, 32);

    // Good byte
    send(8'h41, 1'b1, -1);
    hold(1'b1, 32);
    check("good_cnt",  valid_cnt, 1);
    check("good_byte", got_at(0), 32'h41);
    check("good_data", {24'h0, rx_data}, 32'h41);
    check("good_ferr", ferr_cnt, 0);
    check("good_drop", bad_drop, 0);
    check("good_idle_busy", 32'(rx_busy), 0);

    // Back-to-back frames
    send(8'h4C, 1'b1, -1);
    send(8'h51, 1'b1, -1);
    send(8'h6C, 1'b1, -1);
    hold(1'b1, 32);
    check("b2b_cnt", valid_cnt, 4);
    check("b2b_0", got_at(1), 32'h4C);
    check("b2b_1", got_at(2), 32'h51);
    check("b2b_2", got_at(3), 32'h6C);

    // False start
    br0 = busy_rise;
    hold(1'b0, 4);
    hold(1'b1, 32);
    check("false_cnt",  valid_cnt, 4);
    check("false_ferr", ferr_cnt, 0);
    check("false_busy", busy_rise, br0);
    send(8'h46, 1'b1, -1);
    hold(1'b1, 32);
    check("after_false", got_at(4), 32'h46);

    // Single-tick glitch in data bit 3
    send(8'h41, 1'b1, 3);
    hold(1'b1, 32);
    check("noise_cnt",  valid_cnt, 6);
    check("noise_byte", got_at(5), 32'h41);

    // Framing error followed by line low
    send(8'h51, 1'b0, -1);
    hold(1'b0, 32);
    @(negedge clk);
    check("ferr_busy",  32'(rx_busy), 1);
    check("ferr_cnt",   ferr_cnt, 1);
    check("ferr_valid", valid_cnt, 6);
    check("ferr_data",  {24'h0, rx_data}, 32'h51);
    hold(1'b1, 32);
    check("ferr_recover_busy", 32'(rx_busy), 0);
    send(8'h41, 1'b1, -1);
    hold(1'b1, 32);
    check("post_ferr_cnt",  valid_cnt, 7);
    check("post_ferr_byte", got_at(6), 32'h41);

    // Reset during data bit 4 of 0x4C
    pb = 8'h4C;
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(pb[i], 16);
    hold(pb[4], 8);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check("mid_rst_data",  {24'h0, rx_data}, 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_ferr",  32'(frame_err), 0);
    check("mid_rst_busy",  32'(rx_busy), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    hold(1'b1, 32);
    check("abort_cnt",  valid_cnt, 7);
    check("abort_ferr", ferr_cnt, 1);
    send(8'h41, 1'b1, -1);
    hold(1'b1, 32);
    check("post_rst_cnt",  valid_cnt, 8);
    check("post_rst_data", {24'h0, rx_data}, 32'h41);

    // rx_tick held high every clk
    tick_div = 1;
    hold(1'b1, 40);
    send(8'h6C, 1'b1, -1);
    hold(1'b1, 40);
    check("fast_cnt",  valid_cnt, 9);
    check("fast_byte", got_at(8), 32'h6C);

    check("pulse_len",   bad_len, 0);
    check("both_high",   both_hi, 0);
    check("busy_drop",   bad_drop, 0);
    check("total_ferr",  ferr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
